// File: rtl/writeback_stage.sv
// RV32I writeback stage: MEM/WB register, load align/extend with a stall-safe
// copy of the BRAM word, x0 write suppression, forwarding and retire counter.
module writeback_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             flush,
  input  logic             m_valid,
  input  logic             m_reg_write,
  input  logic [4:0]       m_rd,
  input  logic [1:0]       m_wb_sel,
  input  logic [2:0]       m_funct3,
  input  logic [XLEN-1:0]  m_alu_result,
  input  logic [XLEN-1:0]  m_pc_plus4,
  input  logic [XLEN-1:0]  m_imm,
  input  logic [XLEN-1:0]  mem_rdata,
  output logic             rf_we,
  output logic [4:0]       rf_wa,
  output logic [XLEN-1:0]  rf_wd,
  output logic             fwd_valid,
  output logic [4:0]       fwd_rd,
  output logic [XLEN-1:0]  fwd_data,
  output logic [CNT_W-1:0] instret
);

  logic             wb_valid;
  logic             wb_reg_write;
  logic [4:0]       wb_rd;
  logic [1:0]       wb_wb_sel;
  logic [2:0]       wb_funct3;
  logic [1:0]       wb_addr_lo;
  logic [XLEN-1:0]  wb_alu;
  logic [XLEN-1:0]  wb_pc4;
  logic [XLEN-1:0]  wb_imm;
  logic [XLEN-1:0]  ld_hold;
  logic             ld_captured;
  logic [CNT_W-1:0] instret_q;

  logic [XLEN-1:0]  ld_word;
  logic [7:0]       ld_byte;
  logic [15:0]      ld_half;
  logic [XLEN-1:0]  ld_result;
  logic [XLEN-1:0]  result;
  logic             writes_rd;

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_valid     <= 1'b0;
      wb_reg_write <= 1'b0;
      wb_rd        <= '0;
      wb_wb_sel    <= '0;
      wb_funct3    <= '0;
      wb_addr_lo   <= '0;
      wb_alu       <= '0;
      wb_pc4       <= '0;
      wb_imm       <= '0;
      ld_hold      <= '0;
      ld_captured  <= 1'b0;
      instret_q    <= '0;
    end else if (!stall) begin
      if (wb_valid) instret_q <= instret_q + CNT_W'(1);
      wb_valid     <= m_valid & ~flush;
      wb_reg_write <= m_reg_write;
      wb_rd        <= m_rd;
      wb_wb_sel    <= m_wb_sel;
      wb_funct3    <= m_funct3;
      wb_addr_lo   <= m_alu_result[1:0];
      wb_alu       <= m_alu_result;
      wb_pc4       <= m_pc_plus4;
      wb_imm       <= m_imm;
      ld_captured  <= 1'b0;
    end else if (wb_valid && !ld_captured) begin
      // BRAM output is only valid in the first WB cycle; keep it for long stalls
      ld_hold     <= mem_rdata;
      ld_captured <= 1'b1;
    end
  end

  always_comb begin
    ld_word = ld_captured ? ld_hold : mem_rdata;
    case (wb_addr_lo)
      2'd0:    ld_byte = ld_word[7:0];
      2'd1:    ld_byte = ld_word[15:8];
      2'd2:    ld_byte = ld_word[23:16];
      default: ld_byte = ld_word[31:24];
    endcase
    ld_half = wb_addr_lo[1] ? ld_word[31:16] : ld_word[15:0];
    case (wb_funct3)
      3'b000:  ld_result = {{(XLEN-8){ld_byte[7]}}, ld_byte};
      3'b100:  ld_result = {{(XLEN-8){1'b0}}, ld_byte};
      3'b001:  ld_result = {{(XLEN-16){ld_half[15]}}, ld_half};
      3'b101:  ld_result = {{(XLEN-16){1'b0}}, ld_half};
      3'b010:  ld_result = ld_word;
      default: ld_result = '0;
    endcase
  end

  always_comb begin
    case (wb_wb_sel)
      2'b00:   result = wb_alu;
      2'b01:   result = ld_result;
      2'b10:   result = wb_pc4;
      default: result = wb_imm;
    endcase
  end

  assign writes_rd = wb_valid & wb_reg_write & (wb_rd != 5'd0);

  assign rf_we     = writes_rd & ~stall;
  assign rf_wa     = wb_rd;
  assign rf_wd     = result;
  assign fwd_valid = writes_rd;
  assign fwd_rd    = wb_rd;
  assign fwd_data  = result;
  assign instret   = instret_q;

endmodule

// File: tb/tb_writeback_stage.sv
// Bench for writeback_stage: directed cases plus random traffic, all checked
// against a transaction-level model of the WB instruction and retire count.
module tb_writeback_stage;
  localparam int CW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, stall, flush, m_valid, m_reg_write;
  logic [4:0] m_rd;
  logic [1:0] m_wb_sel;
  logic [2:0] m_funct3;
  logic [31:0] m_alu_result, m_pc_plus4, m_imm, mem_rdata;
  logic rf_we, fwd_valid;
  logic [4:0] rf_wa, fwd_rd;
  logic [31:0] rf_wd, fwd_data;
  logic [CW-1:0] instret;

  writeback_stage #(.XLEN(32), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .m_valid(m_valid), .m_reg_write(m_reg_write), .m_rd(m_rd),
    .m_wb_sel(m_wb_sel), .m_funct3(m_funct3), .m_alu_result(m_alu_result),
    .m_pc_plus4(m_pc_plus4), .m_imm(m_imm), .mem_rdata(mem_rdata),
    .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd),
    .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
    .instret(instret)
  );

  int total = 0;
  int bad = 0;

  // The instruction currently sitting in WB, as a transaction.
  typedef struct {
    bit v; bit we; bit [4:0] rd; bit [1:0] sel; bit [2:0] f3;
    bit [31:0] alu; bit [31:0] pc4; bit [31:0] imm;
    bit [31:0] word; bit have_word;
  } ent_t;
  ent_t wb;
  logic [CW-1:0] retired;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] load_val(input logic [31:0] w, input logic [2:0] f3,
                                           input logic [1:0] a);
    logic [31:0] b, h;
    b = (w >> (8 * a)) & 32'hFF;
    h = (w >> (16 * a[1])) & 32'hFFFF;
    case (f3)
      3'b000:  return b[7] ? (b | 32'hFFFFFF00) : b;
      3'b100:  return b;
      3'b001:  return h[15] ? (h | 32'hFFFF0000) : h;
      3'b101:  return h;
      3'b010:  return w;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] model_result();
    logic [31:0] w;
    w = wb.have_word ? wb.word : mem_rdata;
    case (wb.sel)
      2'd0:    return wb.alu;
      2'd1:    return load_val(w, wb.f3, wb.alu[1:0]);
      2'd2:    return wb.pc4;
      default: return wb.imm;
    endcase
  endfunction

  task automatic offer(input bit v, input bit we, input logic [4:0] rd, input logic [1:0] sel,
                       input logic [2:0] f3, input logic [31:0] alu,
                       input logic [31:0] pc4, input logic [31:0] imm);
    m_valid = v; m_reg_write = we; m_rd = rd; m_wb_sel = sel; m_funct3 = f3;
    m_alu_result = alu; m_pc_plus4 = pc4; m_imm = imm;
  endtask

  task automatic idle();
    offer(1'b0, 1'b0, 5'd0, 2'd0, 3'd0, 32'h0, 32'h0, 32'h0);
  endtask

  // Checks outputs for the current inputs, then clocks once and advances the model.
  task automatic cyc(input string tag);
    bit exp_fwd;
    #1;
    exp_fwd = wb.v && wb.we && (wb.rd != 5'd0);
    check({tag, ".fwd_valid"}, {63'd0, fwd_valid}, {63'd0, exp_fwd});
    if (exp_fwd) begin
      check({tag, ".fwd_rd"}, {59'd0, fwd_rd}, {59'd0, wb.rd});
      check({tag, ".fwd_data"}, {32'd0, fwd_data}, {32'd0, model_result()});
    end
    check({tag, ".rf_we"}, {63'd0, rf_we}, {63'd0, exp_fwd && !stall});
    if (exp_fwd && !stall) begin
      check({tag, ".rf_wa"}, {59'd0, rf_wa}, {59'd0, wb.rd});
      check({tag, ".rf_wd"}, {32'd0, rf_wd}, {32'd0, model_result()});
    end
    check({tag, ".instret"}, {60'd0, instret}, {60'd0, retired});
    @(posedge clk);
    if (rst) begin
      wb = '{default: 0};
      retired = '0;
    end else if (!stall) begin
      if (wb.v) retired = retired + 1'b1;
      wb.v = m_valid && !flush; wb.we = m_reg_write; wb.rd = m_rd;
      wb.sel = m_wb_sel; wb.f3 = m_funct3; wb.alu = m_alu_result;
      wb.pc4 = m_pc_plus4; wb.imm = m_imm; wb.have_word = 0;
    end else if (wb.v && !wb.have_word) begin
      wb.word = mem_rdata;
      wb.have_word = 1;
    end
    #1;
  endtask

  task automatic expect_wr(input string tag, input logic [4:0] a, input logic [31:0] d);
    #1;
    check({tag, ".we"}, {63'd0, rf_we}, 64'd1);
    check({tag, ".wa"}, {59'd0, rf_wa}, {59'd0, a});
    check({tag, ".wd"}, {32'd0, rf_wd}, {32'd0, d});
  endtask

  initial begin
    logic [2:0]  lf3 [6];
    logic [1:0]  lad [6];
    logic [31:0] lexp [6];
    logic [CW-1:0] cnt0;
    wb = '{default: 0};
    retired = '0;
    rst = 1'b1; stall = 1'b1; flush = 1'b0; mem_rdata = 32'h0;
    offer(1'b1, 1'b1, 5'd3, 2'd0, 3'd0, 32'h0000_0033, 32'h0, 32'h0);
    @(posedge clk); #1;
    cyc("rst0");
    cyc("rst1");

    rst = 1'b0; stall = 1'b0;
    #1;
    check("reset.rf_we", {63'd0, rf_we}, 64'd0);
    check("reset.rf_wa", {59'd0, rf_wa}, 64'd0);
    check("reset.rf_wd", {32'd0, rf_wd}, 64'd0);
    check("reset.fwd_valid", {63'd0, fwd_valid}, 64'd0);
    check("reset.instret", {60'd0, instret}, 64'd0);

    offer(1'b1, 1'b1, 5'd5, 2'd0, 3'd0, 32'h1234_5678, 32'h0, 32'h0);
    cyc("alu");
    offer(1'b1, 1'b1, 5'd6, 2'd3, 3'd0, 32'h0, 32'h0, 32'hABCD_E000);
    expect_wr("alu_wr", 5'd5, 32'h1234_5678);
    cyc("lui");
    offer(1'b1, 1'b1, 5'd1, 2'd2, 3'd0, 32'h0, 32'h0000_0104, 32'h0);
    expect_wr("lui_wr", 5'd6, 32'hABCD_E000);
    cyc("jal");
    idle();
    expect_wr("jal_wr", 5'd1, 32'h0000_0104);
    cyc("jal_ret");
    #1;
    check("three.instret", {60'd0, instret}, 64'd3);
    check("three.rf_we", {63'd0, rf_we}, 64'd0);
    cyc("idle");

    lf3 = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010, 3'b011};
    lad = '{2'd3, 2'd3, 2'd2, 2'd0, 2'd2, 2'd0};
    lexp = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80FF, 32'h0000_7F01,
             32'h80FF_7F01, 32'h0000_0000};
    mem_rdata = 32'h80FF_7F01;
    for (int i = 0; i < 6; i++) begin
      offer(1'b1, 1'b1, 5'(10 + i), 2'd1, lf3[i], 32'h0000_1000 | 32'(lad[i]), 32'h0, 32'h0);
      cyc("ld");
      idle();
      expect_wr($sformatf("ld%0d", i), 5'(10 + i), lexp[i]);
      cyc("ld_wr");
    end

    offer(1'b1, 1'b1, 5'd7, 2'd1, 3'b010, 32'h0000_2000, 32'h0, 32'h0);
    cyc("lw7");
    idle();
    cnt0 = retired;
    mem_rdata = 32'hDEAD_BEEF;
    stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("stall.rf_we", {63'd0, rf_we}, 64'd0);
      check("stall.fwd_data", {32'd0, fwd_data}, 64'hDEAD_BEEF);
      cyc("stall");
      mem_rdata = 32'h0;
    end
    stall = 1'b0;
    expect_wr("stall_rel", 5'd7, 32'hDEAD_BEEF);
    cyc("stall_rel");
    check("stall.instret", {60'd0, instret}, {60'd0, 4'(cnt0 + 1'b1)});

    offer(1'b1, 1'b1, 5'd0, 2'd0, 3'd0, 32'h55, 32'h0, 32'h0);
    cyc("x0");
    idle();
    cnt0 = retired;
    #1;
    check("x0.rf_we", {63'd0, rf_we}, 64'd0);
    check("x0.fwd_valid", {63'd0, fwd_valid}, 64'd0);
    cyc("x0_ret");
    check("x0.instret", {60'd0, instret}, {60'd0, 4'(cnt0 + 1'b1)});

    offer(1'b1, 1'b1, 5'd9, 2'd0, 3'd0, 32'h99, 32'h0, 32'h0);
    flush = 1'b1;
    cyc("flush");
    flush = 1'b0;
    idle();
    cnt0 = retired;
    #1;
    check("flush.rf_we", {63'd0, rf_we}, 64'd0);
    check("flush.fwd_valid", {63'd0, fwd_valid}, 64'd0);
    cyc("flush_ret");
    check("flush.instret", {60'd0, instret}, {60'd0, cnt0});

    for (int i = 0; i < 40 && retired != 4'd15; i++) begin
      offer(1'b1, 1'b1, 5'd2, 2'd0, 3'd0, 32'(i), 32'h0, 32'h0);
      cyc("fill");
    end
    check("wrap.pre", {60'd0, instret}, 64'd15);
    offer(1'b1, 1'b1, 5'd2, 2'd0, 3'd0, 32'h7, 32'h0, 32'h0);
    cyc("wrap_a");
    idle();
    cyc("wrap_b");
    check("wrap.post", {60'd0, instret}, 64'd1);

    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 49) == 0);
      stall = ($urandom_range(0, 2) == 0);
      flush = ($urandom_range(0, 5) == 0);
      offer(1'($urandom), 1'($urandom), 5'($urandom), 2'($urandom), 3'($urandom),
            $urandom, $urandom, $urandom);
      mem_rdata = $urandom;
      cyc("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
- Final (WB) pipeline stage of the RV32I core; sits directly upstream of the register file and drives its single write port.
- Holds the MEM/WB pipeline register and selects the result source.
- Aligns and sign/zero-extends load data from the synchronous data memory.
- Suppresses writes to x0, exposes forwarding info to the hazard logic, and counts retired instructions.

Parameters:
- XLEN, 32, datapath width (only 32 supported)
- CNT_W, 64, width of retired-instruction counter

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- stall  in  1  hold WB register; current WB instruction does not retire this cycle
- flush  in  1  discard the instruction offered on m_* (bubble into WB)
- m_valid  in  1  MEM stage holds a valid instruction
- m_reg_write  in  1  instruction writes rd
- m_rd  in  5  destination register
- m_wb_sel  in  2  00 ALU, 01 load, 10 PC+4, 11 immediate (LUI)
- m_funct3  in  3  load type
- m_alu_result  in  32  ALU result / load effective address
- m_pc_plus4  in  32  link value for JAL/JALR
- m_imm  in  32  U-immediate
- mem_rdata  in  32  raw data-memory word; valid in the first WB cycle of a load (1-cycle BRAM)
- rf_we  out  1  register-file write enable
- rf_wa  out  5  register-file write address
- rf_wd  out  32  register-file write data
- fwd_valid  out  1  WB result is forwardable
- fwd_rd  out  5  forwarded register
- fwd_data  out  32  forwarded value (equals rf_wd)
- instret  out  CNT_W  retired-instruction count

Behaviour:
- Registered state: wb_valid, wb_reg_write, wb_rd, wb_wb_sel, wb_funct3, wb_addr_lo[1:0], wb_alu, wb_pc4, wb_imm, ld_hold[31:0], ld_captured, instret.
- Reset (rst=1 at edge):
  - wb_valid=0, ld_captured=0, instret=0, all other state 0.
  - Outputs after reset: rf_we=0, rf_wa=0, rf_wd=0, fwd_valid=0, instret=0.
  - Reset wins over stall and flush, including mid-stall.
- Capture at each edge when rst=0 and stall=0:
  - wb_valid <= m_valid & ~flush.
  - All other fields <= m_*; ld_captured <= 0.
- stall=1: WB register holds; flush is ignored that cycle because upstream also holds.
- Load-data hold:
  - On the first edge after capture where wb_valid=1 and ld_captured=0: ld_hold <= mem_rdata, ld_captured <= 1.
  - Load source is mem_rdata when ld_captured=0, else ld_hold.
  - Result: load data remains correct across arbitrarily long stalls even if mem_rdata changes.
- Load extraction (little-endian; byte select = wb_addr_lo):
  - 000 LB: byte, sign-extended.
  - 100 LBU: byte, zero-extended.
  - 001 LH / 101 LHU: halfword selected by addr_lo[1]; addr_lo[0] ignored; sign- or zero-extended respectively.
  - 010 LW: full word; addr_lo ignored.
  - 011, 110, 111: result 0.
- Result mux (combinational from WB state): wb_sel 00 wb_alu, 01 load result, 10 wb_pc4, 11 wb_imm.
- Write port:
  - rf_we = wb_valid & wb_reg_write & (wb_rd != 0) & ~stall.
  - rf_wa = wb_rd, rf_wd = result.
  - Latency: instruction accepted at edge N; register file written at edge N+1 (or at the first unstalled edge after it).
- Forwarding: fwd_valid = wb_valid & wb_reg_write & (wb_rd != 0), independent of stall; fwd_rd = wb_rd; fwd_data = result.
- Retirement: instret increments by 1 at each edge where wb_valid=1, stall=0, rst=0. Wraps modulo 2^CNT_W. Bubbles never count.
- A write to x0 retires (instret increments) but rf_we stays 0.

Test Plan:
- Reset: rst=1 for 2 cycles with m_valid=1, stall=1 -> rf_we=0, fwd_valid=0, instret=0; first unstalled capture after release retires normally.
- ALU/LUI/JAL: back-to-back rd=5 ALU 0x12345678, rd=6 LUI imm 0xABCDE000, rd=1 PC+4 0x00000104 -> rf_we pulses one cycle each with matching wa/wd; instret=3.
- Loads from word 0x80FF7F01: LB@addr+3 -> 0xFFFFFF80; LBU@+3 -> 0x00000080; LH@+2 -> 0xFFFF80FF; LHU@+0 -> 0x00007F01; LW -> 0x80FF7F01; funct3=011 -> 0.
- Stall during load: LW rd=7 with mem_rdata=0xDEADBEEF, then stall for 4 cycles while mem_rdata changes to 0 -> rf_we=0 while stalled, fwd_data=0xDEADBEEF throughout, single write of 0xDEADBEEF on release; instret +1 only.
- x0 and flush: ALU write to rd=0 -> rf_we=0, fwd_valid=0, instret +1. Instruction offered with flush=1 -> no write, instret unchanged.
- Counter wrap: preload instret near 2^CNT_W-1 (force or CNT_W=4 build), retire 2 -> wraps to 1.
